// File: rtl/bus_if_ext.sv
// Bus master interface for one memory-accessing pipeline stage: decodes accesses to the
// local scratchpad or the arbitrated bus, runs the req/grant/strobe/ready handshake, and
// aborts stuck bus cycles with a watchdog.
module bus_if_ext #(
  parameter int              AW      = 30,
  parameter int              DW      = 32,
  parameter int              TAG_W   = 3,
  parameter logic [TAG_W-1:0] SPM_TAG = 3'b001,
  parameter int              TIMEOUT = 256,
  parameter int              CNT_W   = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  output logic          busy,
  input  logic [AW-1:0] addr,
  input  logic          as_,
  input  logic          rw,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          err,
  input  logic [DW-1:0] spm_rd_data,
  output logic [AW-1:0] spm_addr,
  output logic          spm_as_,
  output logic          spm_rw,
  output logic [DW-1:0] spm_wr_data,
  input  logic [DW-1:0] bus_rd_data,
  input  logic          bus_rdy_,
  input  logic          bus_grnt_,
  output logic          bus_req_,
  output logic [AW-1:0] bus_addr,
  output logic          bus_as_,
  output logic          bus_rw,
  output logic [DW-1:0] bus_wr_data
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [DW-1:0]    rd_buf, rd_buf_nxt;
  logic [CNT_W-1:0] wd, wd_nxt;
  logic             req_nxt, as_nxt, rw_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [DW-1:0]    wdata_nxt;

  logic tag_hit, spm_hit, bus_start, in_bus, rdy_hit, timeout;

  assign tag_hit   = (addr[AW-1:AW-TAG_W] == SPM_TAG);
  assign spm_hit   = (state == IDLE) && !as_ && !flush && tag_hit;
  assign bus_start = (state == IDLE) && !as_ && !flush && !tag_hit;
  assign in_bus    = (state == REQ) || (state == ACCESS);
  assign rdy_hit   = (state == ACCESS) && !bus_rdy_;
  // A ready arriving on the last allowed cycle completes normally instead of aborting.
  assign timeout   = (TIMEOUT != 0) && in_bus && !rdy_hit && (wd == WD_LAST);

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = !spm_hit;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    rd_buf_nxt = rd_buf;
    wd_nxt     = wd;
    req_nxt    = bus_req_;
    as_nxt     = bus_as_;
    addr_nxt   = bus_addr;
    rw_nxt     = bus_rw;
    wdata_nxt  = bus_wr_data;
    busy       = 1'b0;
    err        = 1'b0;
    rd_data    = rd_buf;

    case (state)
      IDLE: begin
        if (spm_hit) begin
          rd_data = spm_rd_data;
        end else if (bus_start) begin
          busy      = 1'b1;
          addr_nxt  = addr;
          rw_nxt    = rw;
          wdata_nxt = wr_data;
          req_nxt   = 1'b0;
          wd_nxt    = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy   = 1'b1;
        wd_nxt = wd + CNT_W'(1);
        if (!bus_grnt_) begin
          as_nxt    = 1'b0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        as_nxt = 1'b1;
        wd_nxt = wd + CNT_W'(1);
        if (rdy_hit) begin
          busy    = 1'b0;
          rd_data = bus_rd_data;
          if (bus_rw) rd_buf_nxt = bus_rd_data;
          req_nxt   = 1'b1;
          state_nxt = stall ? STALL : IDLE;
        end
      end
      STALL: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (timeout) begin
      err        = 1'b1;
      busy       = 1'b0;
      rd_data    = '0;
      rd_buf_nxt = '0;
      req_nxt    = 1'b1;
      as_nxt     = 1'b1;
      state_nxt  = stall ? STALL : IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rd_buf      <= '0;
      wd          <= '0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_addr    <= '0;
      bus_rw      <= 1'b1;
      bus_wr_data <= '0;
    end else begin
      state       <= state_nxt;
      rd_buf      <= rd_buf_nxt;
      wd          <= wd_nxt;
      bus_req_    <= req_nxt;
      bus_as_     <= as_nxt;
      bus_addr    <= addr_nxt;
      bus_rw      <= rw_nxt;
      bus_wr_data <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_bus_if_ext.sv
// Directed bench for bus_if_ext: a transaction-level model checked every cycle, plus
// literal expectations for SPM hits, bus read/write, stall hold, timeout, flush and reset.
module tb_bus_if_ext;

  localparam int AW      = 30;
  localparam int DW      = 32;
  localparam int TAG_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam logic [TAG_W-1:0] SPM_TAG = 3'b001;

  logic          clk = 1'b0;
  logic          reset, stall, flush, as_, rw, bus_rdy_, bus_grnt_;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, spm_rd_data, bus_rd_data;
  logic          busy, err, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
  logic [DW-1:0] rd_data, spm_wr_data, bus_wr_data;
  logic [AW-1:0] spm_addr, bus_addr;

  bus_if_ext #(.AW(AW), .DW(DW), .TAG_W(TAG_W), .SPM_TAG(SPM_TAG),
               .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data), .err(err),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding bus transaction with its age in cycles.
  bit            m_txn, m_granted, m_hold, chk_en;
  int            m_age;
  logic [DW-1:0] m_buf;
  logic          m_req_n, m_as_n, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  bit            e_spm, e_start, e_rdy, e_to, e_busy;
  logic [DW-1:0] e_rd;

  always_comb begin
    e_spm   = !m_txn && !m_hold && !as_ && !flush && ((addr >> (AW - TAG_W)) == AW'(SPM_TAG));
    e_start = !m_txn && !m_hold && !as_ && !flush && ((addr >> (AW - TAG_W)) != AW'(SPM_TAG));
    e_rdy   = m_txn && m_granted && !bus_rdy_;
    e_to    = m_txn && !e_rdy && (m_age == TIMEOUT);
    e_busy  = e_start || (m_txn && !(e_rdy || e_to));
    e_rd    = e_spm ? spm_rd_data : e_rdy ? bus_rd_data : e_to ? '0 : m_buf;
  end

  always @(posedge clk) begin
    bit start_c, rdy_c, to_c;
    start_c = e_start;
    rdy_c   = e_rdy;
    to_c    = e_to;
    if (!reset) begin
      m_txn = 0; m_granted = 0; m_hold = 0; m_age = 0; m_buf = '0;
      m_req_n = 1; m_as_n = 1; m_rw = 1; m_addr = '0; m_wdata = '0;
    end else if (start_c) begin
      m_txn = 1; m_granted = 0; m_age = 1; m_req_n = 0;
      m_addr = addr; m_rw = rw; m_wdata = wr_data;
    end else if (m_txn) begin
      m_as_n = 1;
      if (rdy_c || to_c) begin
        m_txn   = 0;
        m_req_n = 1;
        m_hold  = stall;
        if (rdy_c && m_rw) m_buf = bus_rd_data;
        if (to_c) m_buf = '0;
      end else begin
        m_age++;
        if (!m_granted && !bus_grnt_) begin
          m_granted = 1;
          m_as_n    = 0;
        end
      end
    end else if (m_hold && !stall) begin
      m_hold = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("err", err, e_to);
      check("spm_as_", spm_as_, !e_spm);
      check("spm_addr", spm_addr, addr);
      check("spm_rw", spm_rw, rw);
      check("spm_wr_data", spm_wr_data, wr_data);
      check("bus_req_", bus_req_, m_req_n);
      check("bus_as_", bus_as_, m_as_n);
      check("bus_addr", bus_addr, m_addr);
      check("bus_rw", bus_rw, m_rw);
      check("bus_wr_data", bus_wr_data, m_wdata);
      if (!e_busy) check("rd_data", rd_data, e_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int nb, na, ne;

  initial begin
    reset = 0; stall = 0; flush = 0; as_ = 1; rw = 1; bus_rdy_ = 1; bus_grnt_ = 1;
    addr = '0; wr_data = '0; spm_rd_data = 32'hDEAD_BEEF; bus_rd_data = '0;
    step();
    chk_en = 1;
    step();
    reset = 1;
    #3;
    check("rst_req", bus_req_, 1'b1);
    check("rst_as", bus_as_, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", rd_data, 32'h0);
    step();

    // SPM read: zero wait states
    addr = 30'h0800_0010; as_ = 0;
    #3;
    check("spm_rd", rd_data, 32'hDEAD_BEEF);
    check("spm_busy", busy, 1'b0);
    check("spm_strobe", spm_as_, 1'b0);
    check("spm_req", bus_req_, 1'b1);
    step();

    // Bus read: grant on second REQ cycle, ready on fourth ACCESS cycle
    addr = 30'h1000_0004; bus_rd_data = 32'h1234_5678;
    nb = 0; na = 0;
    for (int i = 0; i < 8; i++) begin
      as_ = (i == 0) ? 1'b0 : 1'b1;
      bus_grnt_ = (i == 2) ? 1'b0 : 1'b1;
      bus_rdy_  = (i == 6) ? 1'b0 : 1'b1;
      #3;
      if (busy) nb++;
      if (!bus_as_) na++;
      if (i == 6) check("rd_at_rdy", rd_data, 32'h1234_5678);
      if (i == 7) check("req_released", bus_req_, 1'b1);
      step();
    end
    check("busy_cycles", nb, 6);
    check("as_low_cycles", na, 1);
    #3;
    check("rd_buf_read", rd_data, 32'h1234_5678);
    step();

    // Bus write completing under stall; as_ during STALL must not start a new access
    addr = 30'h1000_0008; rw = 0; wr_data = 32'hCAFE_F00D; bus_rd_data = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      as_ = (i == 0 || i == 3) ? 1'b0 : 1'b1;
      bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bus_rdy_  = (i == 2) ? 1'b0 : 1'b1;
      stall     = (i == 2 || i == 3) ? 1'b1 : 1'b0;
      #3;
      if (i == 1) check("wr_data_out", bus_wr_data, 32'hCAFE_F00D);
      if (i == 2) check("wr_done_busy", busy, 1'b0);
      if (i == 3) check("stall_busy", busy, 1'b0);
      if (i == 3) check("stall_rd", rd_data, 32'h1234_5678);
      if (i == 5) check("wr_keeps_buf", rd_data, 32'h1234_5678);
      step();
    end
    rw = 1;

    // Timeout: grant never comes
    addr = 30'h1000_0010; ne = 0;
    for (int i = 0; i < 11; i++) begin
      as_ = (i == 0) ? 1'b0 : 1'b1;
      #3;
      if (err) ne++;
      if (i == 7) check("to_err_early", err, 1'b0);
      if (i == 8) begin
        check("to_err", err, 1'b1);
        check("to_rd", rd_data, 32'h0);
        check("to_busy", busy, 1'b0);
      end
      if (i == 9) begin
        check("to_req", bus_req_, 1'b1);
        check("to_rd_buf", rd_data, 32'h0);
      end
      step();
    end
    check("to_pulses", ne, 1);

    // Flush in IDLE blocks both SPM and bus starts
    addr = 30'h0800_0010; as_ = 0; flush = 1;
    #3;
    check("flush_spm", spm_as_, 1'b1);
    step();
    addr = 30'h1000_0020;
    #3;
    check("flush_busy", busy, 1'b0);
    step();
    as_ = 1; flush = 0;
    #3;
    check("flush_no_req", bus_req_, 1'b1);
    step();

    // Flush during ACCESS is ignored
    bus_rd_data = 32'hA5A5_A5A5;
    for (int i = 0; i < 5; i++) begin
      as_ = (i == 0) ? 1'b0 : 1'b1;
      flush = (i >= 1 && i <= 3) ? 1'b1 : 1'b0;
      bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bus_rdy_  = (i == 3) ? 1'b0 : 1'b1;
      #3;
      if (i == 2) check("flush_acc_busy", busy, 1'b1);
      if (i == 3) check("flush_done", busy, 1'b0);
      if (i == 4) check("flush_rd", rd_data, 32'hA5A5_A5A5);
      step();
    end

    // Reset in the middle of ACCESS
    for (int i = 0; i < 4; i++) begin
      as_ = (i == 0) ? 1'b0 : 1'b1;
      bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      reset = (i == 2) ? 1'b0 : 1'b1;
      #3;
      if (i == 2) check("acc_as_low", bus_as_, 1'b0);
      if (i == 3) begin
        check("mid_rst_req", bus_req_, 1'b1);
        check("mid_rst_as", bus_as_, 1'b1);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd", rd_data, 32'h0);
      end
      step();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_if_ext.md
Name: bus_if_ext

Overview:
- Parametrised next-generation CPU bus master interface, one instance per pipeline stage that accesses memory (instruction fetch, memory access).
- Decodes each access to either the local scratchpad (SPM) or the shared arbitrated bus.
- Runs the req_/grnt_/as_/rdy_ bus handshake and tells the pipeline when the stage is busy.
- New over the previous generation:
  - width and SPM-region parameters;
  - a bus timeout watchdog with an error pulse;
  - a STALL hold state that keeps read data stable until the pipeline moves on.

Parameters:
AW, 30, word address width.
DW, 32, data width.
TAG_W, 3, number of upper address bits compared for SPM decode.
SPM_TAG, 3'b001, value of addr[AW-1:AW-TAG_W] that selects the SPM.
TIMEOUT, 256, maximum cycles allowed in REQ+ACCESS before abort; 0 disables the watchdog.
CNT_W, 9, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset
stall  input  1  pipeline stall
flush  input  1  pipeline flush
busy  output  1  bus access in progress; stage must stall
addr  input  AW  access word address
as_  input  1  access strobe, active-low
rw  input  1  1=read, 0=write
wr_data  input  DW  write data
rd_data  output  DW  read data
err  output  1  one-cycle bus timeout pulse
spm_rd_data  input  DW  SPM read data
spm_addr  output  AW  SPM address
spm_as_  output  1  SPM strobe, active-low
spm_rw  output  1  SPM read/write
spm_wr_data  output  DW  SPM write data
bus_rd_data  input  DW  bus read data
bus_rdy_  input  1  bus ready, active-low
bus_grnt_  input  1  bus grant, active-low
bus_req_  output  1  bus request, active-low
bus_addr  output  AW  bus address
bus_as_  output  1  bus address strobe, active-low
bus_rw  output  1  bus read/write
bus_wr_data  output  DW  bus write data

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, rd_buf=0, bus_req_=1, bus_as_=1, bus_addr=0, bus_rw=1, bus_wr_data=0, err=0, watchdog=0.
  - Reset overrides every state, including mid-transaction; bus_req_ releases on the next edge.
- SPM pass-through (combinational, every cycle):
  - spm_addr=addr, spm_rw=rw, spm_wr_data=wr_data.
  - spm_as_=0 only when state==IDLE, as_==0, flush==0 and addr tag==SPM_TAG; otherwise spm_as_=1.
- IDLE:
  - SPM hit: rd_data=spm_rd_data, busy=0, zero wait states.
  - Non-SPM access (as_==0, no flush): busy=1 combinationally; latch addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data; bus_req_<=0; go to REQ.
  - Otherwise: rd_data=rd_buf.
  - flush==1 blocks both SPM and bus starts.
- REQ:
  - busy=1; bus_req_ stays 0.
  - When bus_grnt_==0: bus_as_<=0 and go to ACCESS.
- ACCESS:
  - bus_as_<=1 after exactly one cycle low.
  - busy=1 until bus_rdy_==0.
  - On the bus_rdy_==0 cycle: busy=0 combinationally, rd_data=bus_rd_data combinationally, rd_buf<=bus_rd_data (reads only; writes leave rd_buf unchanged), bus_req_<=1; next state is STALL if stall==1, else IDLE.
- STALL: busy=0, rd_data=rd_buf; go to IDLE when stall==0.
- flush during REQ/ACCESS is ignored; the bus protocol cannot be aborted by the pipeline.
- Watchdog (TIMEOUT!=0):
  - Cleared on entry to REQ; increments each cycle in REQ or ACCESS without bus_rdy_==0.
  - When it equals TIMEOUT-1 and rdy has not arrived: err=1 for one cycle, busy=0 that cycle, rd_buf<=0, rd_data=0, bus_req_<=1, bus_as_<=1; next state follows the ACCESS completion rule (STALL/IDLE).
  - rdy_ and timeout in the same cycle: rdy wins, err=0.
- err is 0 in every other cycle.
- Back-to-back accesses: a new bus start is allowed in the first IDLE cycle after completion; bus_req_ is high for at least one cycle between transactions.

Test Plan:
- Reset then SPM read addr=0x0800_0010 (tag 001), spm_rd_data=0xDEADBEEF -> rd_data=0xDEADBEEF same cycle, busy=0, bus_req_=1.
- Bus read addr=0x1000_0004, grant after 2 cycles, rdy_ after 3 -> bus_as_ low exactly 1 cycle, busy high 6 cycles, rd_buf=bus_rd_data=0x12345678.
- Bus write with stall=1 at rdy_ -> state STALL, rd_buf unchanged, busy=0; deassert stall -> IDLE.
- TIMEOUT=8, grant never asserted -> err pulse on cycle 8 after start, rd_data=0, bus_req_=1 next cycle.
- flush=1 with as_=0 in IDLE -> no spm_as_, no bus_req_; flush=1 during ACCESS -> transaction still completes.
- reset=0 while in ACCESS -> next edge bus_req_=1, bus_as_=1, state IDLE, err=0.
